// File: rtl/mcu_bus_pkg.sv
// Shared types and constants for the MCU parallel-bus bridge.
package mcu_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWrite,
    StRdReq,
    StRdDrv
  } bus_state_e;

  localparam int unsigned BASE_DFLT = 32'hA00;
  localparam logic [15:0] DEAD_WORD = 16'hDEAD;
  localparam int unsigned ERR_CNT_W = 8;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for one asynchronous strobe with rise/fall pulses on the
// synchronised level.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Reset to the idle level so leaving reset never fakes an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/mcu_bus_bridge.sv
// MCU multiplexed-bus bridge: address latch/decode, channel write strobes and read requests,
// AD read-back drive. Define DECODE_ERR_EN to add dec_err_cnt and the 16'hDEAD invalid-read word.
module mcu_bus_bridge
  import mcu_bus_pkg::*;
#(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned CH_W        = 3,
  parameter int unsigned REG_W       = 4,
  parameter int unsigned ADDR_W      = 19,
  parameter int unsigned BASE        = BASE_DFLT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 int_clk,
  input  logic                 rst,
  input  logic                 nadv,
  input  logic                 nwe,
  input  logic                 noe,
  input  logic [15:0]          ad_in,
  input  logic [ADDR_W-17:0]   a_hi,
  output logic [15:0]          ad_out,
  output logic                 ad_oe,
  output logic [NUM_CH-1:0]    wr_en,
  output logic [NUM_CH-1:0]    rd_req,
  output logic [REG_W-1:0]     reg_addr,
  output logic [15:0]          wr_data,
  input  logic [NUM_CH*16-1:0] rd_data,
  output logic                 done_tgl
`ifdef DECODE_ERR_EN
  ,
  output logic [ERR_CNT_W-1:0] dec_err_cnt
`endif
);

  localparam int unsigned BASE_W = ADDR_W - CH_W - REG_W;
  localparam logic [BASE_W-1:0] BASE_V = BASE_W'(BASE);
`ifdef DECODE_ERR_EN
  localparam logic [15:0] INVALID_WORD = DEAD_WORD;
`else
  localparam logic [15:0] INVALID_WORD = 16'h0000;
`endif

  logic nadv_s, nadv_rise, nadv_fall;
  logic nwe_s, nwe_rise, nwe_fall;
  logic noe_s, noe_rise, noe_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_nadv (
    .clk_i  (int_clk),
    .rst_i  (rst),
    .d_i    (nadv),
    .q_o    (nadv_s),
    .rise_o (nadv_rise),
    .fall_o (nadv_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_nwe (
    .clk_i  (int_clk),
    .rst_i  (rst),
    .d_i    (nwe),
    .q_o    (nwe_s),
    .rise_o (nwe_rise),
    .fall_o (nwe_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_noe (
    .clk_i  (int_clk),
    .rst_i  (rst),
    .d_i    (noe),
    .q_o    (noe_s),
    .rise_o (noe_rise),
    .fall_o (noe_fall)
  );

  // Only the rising edge of NADV matters; its level and falling edge are deliberately ignored.
  logic unused_nadv;
  assign unused_nadv = nadv_s ^ nadv_fall;

  // Bus pipeline of the same depth as the strobe synchronisers, so the last stage lines up
  // with the edge pulses.
  logic [ADDR_W-1:0] ad_pipe_q [SYNC_STAGES];
  logic [ADDR_W-1:0] ad_pipe_d [SYNC_STAGES];
  logic [ADDR_W-1:0] bus_s;

  always_comb begin
    ad_pipe_d[0] = {a_hi, ad_in};
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      ad_pipe_d[i] = ad_pipe_q[i-1];
    end
  end

  always_ff @(posedge int_clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        ad_pipe_q[i] <= '0;
      end
    end else begin
      ad_pipe_q <= ad_pipe_d;
    end
  end

  assign bus_s = ad_pipe_q[SYNC_STAGES-1];

  bus_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [NUM_CH-1:0] wr_en_q, wr_en_d;
  logic [NUM_CH-1:0] rd_req_q, rd_req_d;
  logic [15:0]       ad_out_q, ad_out_d;
  logic              ad_oe_q, ad_oe_d;
  logic              done_q, done_d;
  logic              acc_start;

  // Decode of the latched address.
  logic [CH_W-1:0]   ch_fld;
  logic              addr_valid;
  logic [NUM_CH-1:0] ch_oh;
  logic [15:0]       rd_sel;

  always_comb begin
    ch_fld     = addr_q[REG_W+CH_W-1:REG_W];
    addr_valid = (addr_q[ADDR_W-1:CH_W+REG_W] == BASE_V) && (ch_fld != '0) &&
                 (32'(ch_fld) <= NUM_CH);
    ch_oh  = '0;
    rd_sel = INVALID_WORD;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (addr_valid && (32'(ch_fld) == i + 1)) begin
        ch_oh[i] = 1'b1;
        rd_sel   = rd_data[16*i +: 16];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_en_d   = '0;
    rd_req_d  = '0;
    ad_out_d  = ad_out_q;
    ad_oe_d   = ad_oe_q;
    done_d    = done_q;
    acc_start = 1'b0;

    if (nadv_rise) begin
      // A new address always wins and abandons whatever access was in flight.
      addr_d   = bus_s;
      state_d  = StAddr;
      ad_oe_d  = 1'b0;
      ad_out_d = '0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAddr: begin
          if (!nwe_s && !noe_s) begin
            state_d = StIdle;
          end else if (nwe_fall) begin
            wdata_d   = bus_s[15:0];
            acc_start = 1'b1;
            state_d   = StWrite;
          end else if (noe_fall) begin
            rd_req_d  = ch_oh;
            acc_start = 1'b1;
            state_d   = StRdReq;
          end
        end
        StWrite: begin
          if (!nwe_s && !noe_s) begin
            state_d = StIdle;
          end else if (nwe_rise) begin
            wr_en_d = ch_oh;
            done_d  = done_q ^ addr_valid;
            state_d = StIdle;
          end
        end
        StRdReq: begin
          if (!nwe_s && !noe_s) begin
            state_d = StIdle;
          end else begin
            ad_out_d = rd_sel;
            ad_oe_d  = 1'b1;
            state_d  = StRdDrv;
          end
        end
        StRdDrv: begin
          if (!nwe_s && !noe_s) begin
            ad_oe_d  = 1'b0;
            ad_out_d = '0;
            state_d  = StIdle;
          end else if (noe_rise) begin
            ad_oe_d  = 1'b0;
            ad_out_d = '0;
            done_d   = done_q ^ addr_valid;
            state_d  = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge int_clk) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_en_q  <= '0;
      rd_req_q <= '0;
      ad_out_q <= '0;
      ad_oe_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_en_q  <= wr_en_d;
      rd_req_q <= rd_req_d;
      ad_out_q <= ad_out_d;
      ad_oe_q  <= ad_oe_d;
      done_q   <= done_d;
    end
  end

`ifdef DECODE_ERR_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (acc_start && !addr_valid && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge int_clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign dec_err_cnt = err_cnt_q;
`else
  logic unused_acc;
  assign unused_acc = acc_start;
`endif

  assign ad_out   = ad_out_q;
  assign ad_oe    = ad_oe_q;
  assign wr_en    = wr_en_q;
  assign rd_req   = rd_req_q;
  assign reg_addr = addr_q[REG_W-1:0];
  assign wr_data  = wdata_q;
  assign done_tgl = done_q;

endmodule

// File: tb/tb_mcu_bus_bridge.sv
// Randomised bench for mcu_bus_bridge against a transaction-level model of the MCU bus.
module tb_mcu_bus_bridge;

  logic        int_clk;
  logic        rst;
  logic        nadv, nwe, noe;
  logic [15:0] ad_in;
  logic [2:0]  a_hi;
  logic [15:0] ad_out;
  logic        ad_oe;
  logic [2:0]  wr_en, rd_req;
  logic [3:0]  reg_addr;
  logic [15:0] wr_data;
  logic [47:0] rd_data;
  logic        done_tgl;
`ifdef DECODE_ERR_EN
  logic [7:0]  dec_err_cnt;
  localparam logic [15:0] INV_WORD = 16'hDEAD;
`else
  localparam logic [15:0] INV_WORD = 16'h0000;
`endif

  mcu_bus_bridge #(
    .NUM_CH      (3),
    .CH_W        (3),
    .REG_W       (4),
    .ADDR_W      (19),
    .BASE        (32'hA00),
    .SYNC_STAGES (2)
  ) dut (
    .int_clk  (int_clk),
    .rst      (rst),
    .nadv     (nadv),
    .nwe      (nwe),
    .noe      (noe),
    .ad_in    (ad_in),
    .a_hi     (a_hi),
    .ad_out   (ad_out),
    .ad_oe    (ad_oe),
    .wr_en    (wr_en),
    .rd_req   (rd_req),
    .reg_addr (reg_addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .done_tgl (done_tgl)
`ifdef DECODE_ERR_EN
    ,
    .dec_err_cnt (dec_err_cnt)
`endif
  );

  initial int_clk = 1'b0;
  always #5 int_clk = ~int_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: collects strobe activity seen during one transaction.
  int          wr_cnt, rd_cnt, done_cnt;
  logic [2:0]  wr_seen, rd_seen;
  logic [3:0]  wr_reg, rd_reg;
  logic [15:0] wr_dat;
  logic        done_prev;

  initial begin
    wr_cnt = 0; rd_cnt = 0; done_cnt = 0;
    wr_seen = '0; rd_seen = '0; wr_reg = '0; rd_reg = '0; wr_dat = '0; done_prev = 1'b0;
    forever begin
      @(negedge int_clk);
      if (wr_en != 3'b000) begin
        wr_cnt++; wr_seen = wr_en; wr_reg = reg_addr; wr_dat = wr_data;
      end
      if (rd_req != 3'b000) begin
        rd_cnt++; rd_seen = rd_req; rd_reg = reg_addr;
      end
      if (done_tgl !== done_prev) done_cnt++;
      done_prev = done_tgl;
    end
  end

  task automatic clear_mon();
    wr_cnt = 0; rd_cnt = 0; done_cnt = 0;
    wr_seen = '0; rd_seen = '0; done_prev = done_tgl;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge int_clk);
    #2;
  endtask

  // Reference model: decode by plain arithmetic on the address.
  logic [15:0] rdv [3];
  int          exp_err = 0;

  function automatic int ch_of(input logic [18:0] a);
    return (int'(a) / 16) % 8;
  endfunction

  function automatic bit is_valid(input logic [18:0] a);
    return ((int'(a) / 128) == 'hA00) && (ch_of(a) >= 1) && (ch_of(a) <= 3);
  endfunction

  function automatic logic [15:0] exp_read(input logic [18:0] a);
    return is_valid(a) ? rdv[ch_of(a) - 1] : INV_WORD;
  endfunction

  task automatic count_err(input logic [18:0] a);
    if (!is_valid(a) && exp_err < 255) exp_err++;
  endtask

  task automatic addr_phase(input logic [18:0] a);
    ad_in = a[15:0];
    a_hi  = a[18:16];
    nadv  = 1'b0;
    cyc(1 + $urandom_range(2));
    nadv = 1'b1;
    cyc(4 + $urandom_range(2));
  endtask

  task automatic wr_phase(input logic [18:0] a, input logic [15:0] d);
    bit v;
    v = is_valid(a);
    clear_mon();
    ad_in = d;
    nwe   = 1'b0;
    cyc(3 + $urandom_range(4));
    nwe = 1'b1;
    cyc(6);
    count_err(a);
    check_eq("wr_cnt", wr_cnt, v ? 1 : 0);
    check_eq("wr_done", done_cnt, v ? 1 : 0);
    if (v) begin
      check_eq("wr_en", wr_seen, 1 << (ch_of(a) - 1));
      check_eq("wr_reg", wr_reg, int'(a) % 16);
      check_eq("wr_data", wr_dat, d);
    end
`ifdef DECODE_ERR_EN
    check_eq("err_cnt", dec_err_cnt, exp_err);
`endif
  endtask

  task automatic set_rd_data();
    for (int i = 0; i < 3; i++) rdv[i] = 16'($urandom);
    rd_data = {rdv[2], rdv[1], rdv[0]};
  endtask

  task automatic rd_phase(input logic [18:0] a);
    bit v;
    v = is_valid(a);
    clear_mon();
    noe = 1'b0;
    cyc(6);
    check_eq("rd_oe", ad_oe, 1);
    check_eq("rd_out", ad_out, exp_read(a));
    cyc($urandom_range(3));
    noe = 1'b1;
    cyc(5);
    count_err(a);
    check_eq("rd_oe_off", ad_oe, 0);
    check_eq("rd_cnt", rd_cnt, v ? 1 : 0);
    check_eq("rd_done", done_cnt, v ? 1 : 0);
    if (v) begin
      check_eq("rd_req", rd_seen, 1 << (ch_of(a) - 1));
      check_eq("rd_reg", rd_reg, int'(a) % 16);
    end
`ifdef DECODE_ERR_EN
    check_eq("err_cnt", dec_err_cnt, exp_err);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_oe"}, ad_oe, 0);
    check_eq({tag, "_out"}, ad_out, 0);
    check_eq({tag, "_wr"}, wr_en, 0);
    check_eq({tag, "_rd"}, rd_req, 0);
    check_eq({tag, "_reg"}, reg_addr, 0);
    check_eq({tag, "_wdat"}, wr_data, 0);
    check_eq({tag, "_done"}, done_tgl, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [18:0] a;
    int          kind;

    rst = 1'b1; nadv = 1'b1; nwe = 1'b1; noe = 1'b1;
    ad_in = '0; a_hi = '0;
    rdv[0] = 16'hC0DE; rdv[1] = 16'h5A5A; rdv[2] = 16'hBEEF;
    rd_data = {rdv[2], rdv[1], rdv[0]};
    cyc(3);
    check_all_zero("reset");
`ifdef DECODE_ERR_EN
    check_eq("reset_err", dec_err_cnt, 0);
`endif
    rst = 1'b0;
    cyc(2);

    // Directed: the reference write and reads.
    addr_phase(19'h50010);
    wr_phase(19'h50010, 16'h1234);
    addr_phase(19'h5003F);
    rd_phase(19'h5003F);
    addr_phase(19'h50000);
    rd_phase(19'h50000);
    addr_phase(19'h40010);
    rd_phase(19'h40010);

    // NADV during read drive: drop the bus, take the new address, no completion.
    addr_phase(19'h50021);
    clear_mon();
    noe = 1'b0;
    cyc(6);
    check_eq("abort_oe_on", ad_oe, 1);
    addr_phase(19'h50035);
    check_eq("abort_oe_off", ad_oe, 0);
    noe = 1'b1;
    cyc(4);
    check_eq("abort_done", done_cnt, 0);
    wr_phase(19'h50035, 16'hA5C3);

    // NWE and NOE together: abort, then a lone NWE must be ignored in IDLE.
    addr_phase(19'h50012);
    clear_mon();
    nwe = 1'b0; noe = 1'b0;
    cyc(5);
    check_eq("both_oe", ad_oe, 0);
    nwe = 1'b1; noe = 1'b1;
    cyc(5);
    nwe = 1'b0;
    cyc(4);
    nwe = 1'b1;
    cyc(5);
    check_eq("both_wr", wr_cnt, 0);
    check_eq("both_rd", rd_cnt, 0);
    check_eq("both_done", done_cnt, 0);

    // Randomised mix of valid and stray accesses.
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(9);
      if (kind < 7) begin
        a = 19'((32'hA00 << 7) | ($urandom_range(7) << 4) | $urandom_range(15));
      end else begin
        a = 19'($urandom);
      end
      set_rd_data();
      addr_phase(a);
      if ($urandom_range(1) == 0) wr_phase(a, 16'($urandom));
      else rd_phase(a);
    end

    // Reset while driving read data.
    addr_phase(19'h5003F);
    noe = 1'b0;
    cyc(6);
    check_eq("rst_oe_on", ad_oe, 1);
    rst = 1'b1;
    cyc(1);
    check_all_zero("rst_mid");
`ifdef DECODE_ERR_EN
    check_eq("rst_err", dec_err_cnt, 0);
`endif
    exp_err = 0;
    rst = 1'b0;
    noe = 1'b1;
    cyc(4);

`ifdef DECODE_ERR_EN
    for (int t = 0; t < 256; t++) begin
      addr_phase(19'h40010);
      nwe = 1'b0;
      cyc(3);
      nwe = 1'b1;
      cyc(4);
    end
    check_eq("err_sat", dec_err_cnt, 8'hFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
